decode_queue: RTL and testbench
===============================

# decode_queue

Parametrised instruction decode stage for the RV32I/RV64I core. It sits between fetch (IF) and execute (EX) and buffers fetched instruction/PC pairs in a DEPTH-entry queue. Each pair is decoded into register fields, a sign-extended XLEN immediate and an illegal-instruction flag, then presented on a registered output with valid/ready handshakes on both sides. It adds backpressure, pipeline flush and RV64 immediate extension to the basic field/immediate decoder.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64; sets the width of PC and imm.
- DEPTH, 4, raw instruction queue entries; power of two, 2..16.
- clk  input  1  core clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; discards all queued and output-stage instructions.
- in_valid  input  1  IF presents an instruction.
- in_ready  output  1  stage can accept one instruction.
- in_instr  input  32  raw instruction word.
- in_pc  input  XLEN  instruction address.
- out_valid  output  1  decoded instruction available.
- out_ready  input  1  EX consumes the decoded instruction.
- out_pc  output  XLEN  PC of the decoded instruction.
- opcode  output  7  instr[6:0].
- rd_addr  output  5  instr[11:7].
- funct3  output  3  instr[14:12].
- rs1_addr  output  5  instr[19:15].
- rs2_addr  output  5  instr[24:20].
- funct7  output  7  instr[31:25].
- imm  output  XLEN  immediate, sign-extended to XLEN.
- illegal  output  1  instruction is not in the supported set.
- count  output  $clog2(DEPTH+1)  number of occupied queue entries; the output register is excluded.

## Operation
- Storage: a circular queue of DEPTH {instr, pc} entries with wrapping read/write pointers, plus one output register holding the decoded fields. Total capacity is DEPTH+1.
- Accept: a transfer happens when in_valid && in_ready. in_ready = (count != DEPTH) && !flush.
- Output load: the output register loads when it is empty (!out_valid) or being consumed (out_valid && out_ready).
  - If the queue is non-empty, it loads the queue head.
  - Otherwise, if an input transfer is occurring, it loads the input directly (bypass); that input is not written to the queue.
  - Otherwise out_valid goes to 0.
- Simultaneous push and pop to the queue leaves count unchanged.
- Ordering is strictly FIFO.
- Decode is combinational on the selected {instr, pc} and registered into the output stage.
- Immediate by opcode:
  - I-type 0010011, Load 0000011, JALR 1100111: sext(instr[31:20]).
  - Store 0100011: sext({instr[31:25], instr[11:7]}).
  - Branch 1100011: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - LUI 0110111, AUIPC 0010111: sext({instr[31:12], 12'b0}); sign-extended from bit 31 when XLEN=64.
  - JAL 1101111: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R-type 0110011, FENCE 0001111, SYSTEM 1110011, and all others: imm = 0.
- illegal = 1 when instr[1:0] != 2'b11, or when opcode is not one of the eleven values above. Illegal instructions still flow through normally with imm = 0.
- Field outputs (opcode … funct7) are raw slices regardless of the illegal flag.
- Flush:
  - Next cycle: count = 0, pointers equal, out_valid = 0.
  - in_valid in the flush cycle is dropped.
  - Any out_ready handshake in the flush cycle still counts as consumed.

## Timing
- Reset (rst low, asynchronous): out_valid=0, count=0, pointers=0, out_pc=0, all field outputs=0, imm=0, illegal=0, in_ready=1 after release.
- Latency: an instruction accepted in cycle N into an empty stage is on the outputs with out_valid=1 in cycle N+1.
- Throughput: one instruction per cycle sustained when out_ready=1.
- While out_valid && !out_ready, every output is held stable.
- in_ready depends only on count and flush, not combinationally on out_ready.
- Full boundary:
  - At count==DEPTH, in_ready=0.
  - A pop in that cycle raises in_ready in the following cycle, not the same cycle.
- Empty boundary: with count==0 and an output consume, the bypass path prevents a bubble when in_valid=1.
- Reset asserted mid-transfer clears all state immediately; in-flight instructions are lost.

## Test plan
- XLEN=32, send 0xFFF10093 (addi x1,x2,-1) at pc 0x100 → next cycle out_valid=1, opcode=0x13, rd=1, rs1=2, imm=0xFFFFFFFF, out_pc=0x100, illegal=0.
- Send 0xFE000EE3 (beq −4), then 0xFE512C23 (sw x5,−8(x2)), then 0x008000EF (jal x1,8) back-to-back with out_ready=1 → imm sequence 0xFFFFFFFC, 0xFFFFFFF8, 0x00000008 on consecutive cycles, no bubbles.
- XLEN=64, send 0x800002B7 (lui x5,0x80000) → imm=0xFFFFFFFF80000000; send 0x00000000 → illegal=1, imm=0.
- DEPTH=4, out_ready=0, offer 7 instructions → exactly 5 accepted, in_ready=0 with count=4. Then out_ready=1 → all 5 emerge in order, in_ready returns 1 one cycle after the first pop.
- Queue holding 3 and output valid: assert flush with in_valid=1 → next cycle out_valid=0, count=0; later instructions decode normally.
- Assert rst low mid-stream with count=2 → outputs zero asynchronously; after release in_ready=1, out_valid=0.

Source files
------------

// File: rtl/decode_queue_if.sv
// IF/EX-facing handshake bundle for the decode queue: input and output handshakes,
// flush, decoded fields and queue occupancy.
interface decode_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    logic                         flush;
    logic                         in_valid;
    logic                         in_ready;
    logic [31:0]                  in_instr;
    logic [XLEN-1:0]              in_pc;
    logic                         out_valid;
    logic                         out_ready;
    logic [XLEN-1:0]              out_pc;
    logic [6:0]                   opcode;
    logic [4:0]                   rd_addr;
    logic [2:0]                   funct3;
    logic [4:0]                   rs1_addr;
    logic [4:0]                   rs2_addr;
    logic [6:0]                   funct7;
    logic [XLEN-1:0]              imm;
    logic                         illegal;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, opcode, rd_addr, funct3,
               rs1_addr, rs2_addr, funct7, imm, illegal, count
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, opcode, rd_addr, funct3,
               rs1_addr, rs2_addr, funct7, imm, illegal, count
    );
endinterface

// File: rtl/decode_queue.sv
// RV32I/RV64I decode stage: DEPTH-entry {instr, pc} queue feeding a registered
// decode output stage, with empty-queue bypass and synchronous flush.
module decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    decode_queue_if.slave  dq
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic            illegal;
    } dec_t;

    // Every supported opcode ends in 2'b11, so the default arm also covers
    // compressed/invalid low bits.
    function automatic dec_t decode(input logic [31:0] i);
        dec_t d;
        d.imm     = '0;
        d.illegal = 1'b0;
        case (i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111:
                d.imm = XLEN'($signed(i[31:20]));
            7'b0100011:
                d.imm = XLEN'($signed({i[31:25], i[11:7]}));
            7'b1100011:
                d.imm = XLEN'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            7'b0110111, 7'b0010111:
                d.imm = XLEN'($signed({i[31:12], 12'b0}));
            7'b1101111:
                d.imm = XLEN'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            7'b0110011, 7'b0001111, 7'b1110011:
                d.imm = '0;
            default:
                d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    logic [31:0]     mem_instr [DEPTH];
    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   cnt;

    logic            out_valid, out_illegal;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc, out_imm;

    logic            q_empty, push_fire, out_load, pop, bypass, q_push, load_any;
    logic [31:0]     sel_instr;
    logic [XLEN-1:0] sel_pc;
    dec_t            sel_dec;

    assign q_empty   = (cnt == '0);
    assign dq.in_ready = (cnt != CW'(DEPTH)) && !dq.flush;
    assign push_fire = dq.in_valid && dq.in_ready;
    assign out_load  = !out_valid || dq.out_ready;
    assign pop       = out_load && !q_empty;
    assign bypass    = out_load && q_empty && push_fire;
    assign q_push    = push_fire && !bypass;
    assign load_any  = !q_empty || push_fire;

    assign sel_instr = q_empty ? dq.in_instr : mem_instr[rd_ptr];
    assign sel_pc    = q_empty ? dq.in_pc    : mem_pc[rd_ptr];
    assign sel_dec   = decode(sel_instr);

    always_ff @(posedge clk) begin
        if (q_push) begin
            mem_instr[wr_ptr] <= dq.in_instr;
            mem_pc[wr_ptr]    <= dq.in_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            out_imm     <= '0;
            out_illegal <= 1'b0;
        end else if (dq.flush) begin
            // A consume in the flush cycle is honoured simply by dropping out_valid.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (q_push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + CW'(q_push) - CW'(pop);
            if (out_load) begin
                out_valid <= load_any;
                if (load_any) begin
                    out_instr   <= sel_instr;
                    out_pc      <= sel_pc;
                    out_imm     <= sel_dec.imm;
                    out_illegal <= sel_dec.illegal;
                end
            end
        end
    end

    assign dq.out_valid = out_valid;
    assign dq.out_pc    = out_pc;
    assign dq.opcode    = out_instr[6:0];
    assign dq.rd_addr   = out_instr[11:7];
    assign dq.funct3    = out_instr[14:12];
    assign dq.rs1_addr  = out_instr[19:15];
    assign dq.rs2_addr  = out_instr[24:20];
    assign dq.funct7    = out_instr[31:25];
    assign dq.imm       = out_imm;
    assign dq.illegal   = out_illegal;
    assign dq.count     = cnt;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: an XLEN=32 instance for queue/flush/reset
// behaviour and an XLEN=64 instance for upper-word immediate extension.
module tb_decode_queue;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   acc;

    always #5 clk = ~clk;

    decode_queue_if #(.XLEN(32), .DEPTH(4)) a ();
    decode_queue_if #(.XLEN(64), .DEPTH(4)) b ();

    decode_queue #(.XLEN(32), .DEPTH(4)) u32 (.clk(clk), .rst(rst), .dq(a.slave));
    decode_queue #(.XLEN(64), .DEPTH(4)) u64 (.clk(clk), .rst(rst), .dq(b.slave));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        a.in_valid = v;
        a.in_instr = ins;
        a.in_pc    = pc;
    endtask

    initial begin
        a.flush = 1'b0; a.out_ready = 1'b1; drive_a(1'b0, 32'h0, 32'h0);
        b.flush = 1'b0; b.out_ready = 1'b1;
        b.in_valid = 1'b0; b.in_instr = 32'h0; b.in_pc = 64'h0;

        // Reset state
        #1;
        check("rst_out_valid", a.out_valid, 0);
        check("rst_count",     a.count,     0);
        check("rst_imm",       a.imm,       0);
        check("rst_out_pc",    a.out_pc,    0);
        check("rst_opcode",    a.opcode,    0);
        check("rst_illegal",   a.illegal,   0);
        #13 rst = 1'b1;
        step();
        check("rel_in_ready", a.in_ready, 1);

        // addi x1,x2,-1 through the bypass path
        drive_a(1'b1, 32'hFFF10093, 32'h100);
        step();
        drive_a(1'b0, 32'h0, 32'h0);
        check("addi_valid",   a.out_valid, 1);
        check("addi_opcode",  a.opcode,    7'h13);
        check("addi_rd",      a.rd_addr,   1);
        check("addi_rs1",     a.rs1_addr,  2);
        check("addi_imm",     a.imm,       32'hFFFFFFFF);
        check("addi_pc",      a.out_pc,    32'h100);
        check("addi_illegal", a.illegal,   0);

        // Back-to-back beq / sw / jal with no bubbles
        drive_a(1'b1, 32'hFE000EE3, 32'h104); step();
        check("beq_valid", a.out_valid, 1);
        check("beq_imm",   a.imm, 32'hFFFFFFFC);
        drive_a(1'b1, 32'hFE512C23, 32'h108); step();
        check("sw_valid",  a.out_valid, 1);
        check("sw_imm",    a.imm, 32'hFFFFFFF8);
        check("sw_rs2",    a.rs2_addr, 5);
        drive_a(1'b1, 32'h008000EF, 32'h10C); step();
        check("jal_valid", a.out_valid, 1);
        check("jal_imm",   a.imm, 32'h8);
        check("jal_pc",    a.out_pc, 32'h10C);
        check("b2b_count", a.count, 0);
        drive_a(1'b0, 32'h0, 32'h0); step();
        check("drain_valid", a.out_valid, 0);

        // Fill: 7 offers with EX stalled; 1 in output + 4 queued
        a.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            drive_a(1'b1, {12'(i), 5'd0, 3'd0, 5'(i + 1), 7'h13}, 32'h200 + 32'(4 * i));
            if (a.in_ready) acc++;
            step();
        end
        drive_a(1'b0, 32'h0, 32'h0);
        check("full_accepted", 32'(acc), 5);
        check("full_count",    a.count, 4);
        check("full_in_ready", a.in_ready, 0);
        check("full_hold_pc",  a.out_pc, 32'h200);
        check("full_hold_imm", a.imm, 0);
        a.out_ready = 1'b1;
        check("pop_same_cycle_ready", a.in_ready, 0);
        step();
        check("pop_next_ready", a.in_ready, 1);
        check("pop_count",      a.count, 3);
        for (int k = 1; k < 5; k++) begin
            check("order_pc",  a.out_pc, 32'h200 + 32'(4 * k));
            check("order_imm", a.imm, 32'(k));
            check("order_rd",  a.rd_addr, 5'(k + 1));
            step();
        end
        check("fill_drained", a.out_valid, 0);

        // Flush with 3 queued and output valid
        a.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 32'h00000013, 32'h280 + 32'(4 * i));
            step();
        end
        check("preflush_count", a.count, 3);
        check("preflush_valid", a.out_valid, 1);
        a.flush = 1'b1;
        drive_a(1'b1, 32'h00000013, 32'h2A0);
        #1;
        check("flush_in_ready", a.in_ready, 0);
        step();
        a.flush = 1'b0;
        drive_a(1'b0, 32'h0, 32'h0);
        check("flush_valid", a.out_valid, 0);
        check("flush_count", a.count, 0);
        a.out_ready = 1'b1;
        drive_a(1'b1, 32'h00500193, 32'h300);
        step();
        drive_a(1'b0, 32'h0, 32'h0);
        check("postflush_valid", a.out_valid, 1);
        check("postflush_pc",    a.out_pc, 32'h300);
        check("postflush_imm",   a.imm, 5);
        check("postflush_rd",    a.rd_addr, 3);
        step();

        // XLEN=64: LUI upper sign extension and an all-zero word
        b.in_valid = 1'b1; b.in_instr = 32'h800002B7; b.in_pc = 64'h1000;
        step();
        check("lui64_imm",     b.imm, 64'hFFFFFFFF80000000);
        check("lui64_rd",      b.rd_addr, 5);
        check("lui64_illegal", b.illegal, 0);
        b.in_instr = 32'h00000000; b.in_pc = 64'h1004;
        step();
        b.in_valid = 1'b0;
        check("zero64_illegal", b.illegal, 1);
        check("zero64_imm",     b.imm, 0);
        check("zero64_pc",      b.out_pc, 64'h1004);
        step();

        // Asynchronous reset mid-stream with count=2
        a.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 32'hFFF10093, 32'h400 + 32'(4 * i));
            step();
        end
        drive_a(1'b0, 32'h0, 32'h0);
        check("prerst_count", a.count, 2);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", a.out_valid, 0);
        check("arst_count", a.count, 0);
        check("arst_imm",   a.imm, 0);
        check("arst_pc",    a.out_pc, 0);
        #3 rst = 1'b1;
        step();
        check("rel2_in_ready", a.in_ready, 1);
        check("rel2_valid",    a.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
